// File: rtl/vga_stream_gen_pkg.sv
// ============================================================================
// vga_stream_gen_pkg : stream word layout and default 800x600@60 timing
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_stream_gen_pkg;

  localparam int unsigned VGA_W = 26;

  localparam int unsigned DEF_H_VIS  = 800;
  localparam int unsigned DEF_H_FP   = 40;
  localparam int unsigned DEF_H_SYNC = 128;
  localparam int unsigned DEF_H_BP   = 88;
  localparam int unsigned DEF_V_VIS  = 600;
  localparam int unsigned DEF_V_FP   = 1;
  localparam int unsigned DEF_V_SYNC = 4;
  localparam int unsigned DEF_V_BP   = 23;

  localparam logic [9:0] XC_MAX = 10'd1023;

  // Bit map shared by every stream stage: [25:23] BGR, [22:13] XC, [12:3] YC, [2] HS, [1] VS, [0] Active
  typedef struct packed {
    logic [2:0] rgb;
    logic [9:0] xc;
    logic [9:0] yc;
    logic       hs;
    logic       vs;
    logic       active;
  } vga_word_t;

  function automatic logic [9:0] sat_xc(input logic [10:0] h);
    return (h > {1'b0, XC_MAX}) ? XC_MAX : h[9:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_stream_gen.sv
// ============================================================================
// vga_stream_gen : VGA timing counters and registered RGB stream source
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_stream_gen
  import vga_stream_gen_pkg::*;
#(
  parameter int unsigned H_VIS    = DEF_H_VIS,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_VIS    = DEF_V_VIS,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = 1'b1,
  parameter logic [2:0]  BG_RGB   = 3'b000
) (
  input  logic             px_clk,
  input  logic             reset_n,
  output logic [VGA_W-1:0] strRGB_o,
  output logic             frame_start_o,
  output logic             line_start_o
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] c_h_last     = 11'(H_TOT - 1);
  localparam logic [10:0] c_h_vis      = 11'(H_VIS);
  localparam logic [10:0] c_hs_start   = 11'(H_VIS + H_FP);
  localparam logic [10:0] c_hs_end     = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  c_v_last     = 10'(V_TOT - 1);
  localparam logic [9:0]  c_v_vis      = 10'(V_VIS);
  localparam logic [9:0]  c_vs_start   = 10'(V_VIS + V_FP);
  localparam logic [9:0]  c_vs_end     = 10'(V_VIS + V_FP + V_SYNC);

  localparam vga_word_t c_rst_word = '{
    rgb:    BG_RGB,
    xc:     10'd0,
    yc:     10'd0,
    hs:     ~SYNC_POL,
    vs:     ~SYNC_POL,
    active: 1'b0
  };

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  vga_word_t   word_q, word_d;
  logic        frame_start_q, frame_start_d;
  logic        line_start_q, line_start_d;

  logic w_in_hs;
  logic w_in_vs;

  always_ff @(posedge px_clk) begin
    if (!reset_n) begin
      h_q           <= '0;
      v_q           <= '0;
      word_q        <= c_rst_word;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      word_q        <= word_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  // The word is decoded from the counters as they are now, so it lags them by one clock.
  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == c_h_last) begin
      h_d = '0;
      v_d = (v_q == c_v_last) ? 10'd0 : v_q + 10'd1;
    end

    w_in_hs = (h_q >= c_hs_start) && (h_q < c_hs_end);
    w_in_vs = (v_q >= c_vs_start) && (v_q < c_vs_end);

    word_d        = c_rst_word;
    word_d.rgb    = BG_RGB;
    word_d.xc     = sat_xc(h_q);
    word_d.yc     = v_q;
    word_d.hs     = w_in_hs ? SYNC_POL : ~SYNC_POL;
    word_d.vs     = w_in_vs ? SYNC_POL : ~SYNC_POL;
    word_d.active = (h_q < c_h_vis) && (v_q < c_v_vis);

    line_start_d  = (h_q == 11'd0);
    frame_start_d = (h_q == 11'd0) && (v_q == 10'd0);
  end

  assign strRGB_o      = word_q;
  assign frame_start_o = frame_start_q;
  assign line_start_o  = line_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_stream_gen.sv
// ============================================================================
// tb_vga_stream_gen : directed bench for vga_stream_gen (default, inverted sync, small timing)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_stream_gen;

  logic px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  logic        rst0_n, rst1_n, rst2_n;
  logic [25:0] w0, w1, w2;
  logic        fs0, fs1, fs2, ls0, ls1, ls2;

  int n_chk  = 0;
  int n_fail = 0;

  // Default timing, positive sync
  vga_stream_gen u_d0 (
    .px_clk(px_clk), .reset_n(rst0_n), .strRGB_o(w0),
    .frame_start_o(fs0), .line_start_o(ls0)
  );

  // Default timing, negative sync
  vga_stream_gen #(.SYNC_POL(1'b0)) u_d1 (
    .px_clk(px_clk), .reset_n(rst1_n), .strRGB_o(w1),
    .frame_start_o(fs1), .line_start_o(ls1)
  );

  // Shrunk timing: H_TOT=15, V_TOT=8, frame = 120 clocks
  vga_stream_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_d2 (
    .px_clk(px_clk), .reset_n(rst2_n), .strRGB_o(w2),
    .frame_start_o(fs2), .line_start_o(ls2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  typedef struct {
    int         idx;
    logic       act;
    logic       hs;
    logic [9:0] xc;
    logic [9:0] yc;
    logic       fs;
    logic       ls;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [25:0] mk(input logic [9:0] xc, input logic [9:0] yc,
                                     input logic hs, input logic vs, input logic act);
    return {3'b000, xc, yc, hs, vs, act};
  endfunction

  initial begin
    logic [25:0] exp0;
    int ti;
    int act_cnt, hs_cnt, hs_first, hs_last;
    int last_fs, frames, f_act, f_vs, vs_first, vs_last, act_blank;

    tbl[0]  = '{0,    1'b1, 1'b0, 10'd0,    10'd0, 1'b1, 1'b1};
    tbl[1]  = '{1,    1'b1, 1'b0, 10'd1,    10'd0, 1'b0, 1'b0};
    tbl[2]  = '{799,  1'b1, 1'b0, 10'd799,  10'd0, 1'b0, 1'b0};
    tbl[3]  = '{800,  1'b0, 1'b0, 10'd800,  10'd0, 1'b0, 1'b0};
    tbl[4]  = '{839,  1'b0, 1'b0, 10'd839,  10'd0, 1'b0, 1'b0};
    tbl[5]  = '{840,  1'b0, 1'b1, 10'd840,  10'd0, 1'b0, 1'b0};
    tbl[6]  = '{967,  1'b0, 1'b1, 10'd967,  10'd0, 1'b0, 1'b0};
    tbl[7]  = '{968,  1'b0, 1'b0, 10'd968,  10'd0, 1'b0, 1'b0};
    tbl[8]  = '{1022, 1'b0, 1'b0, 10'd1022, 10'd0, 1'b0, 1'b0};
    tbl[9]  = '{1023, 1'b0, 1'b0, 10'd1023, 10'd0, 1'b0, 1'b0};
    tbl[10] = '{1055, 1'b0, 1'b0, 10'd1023, 10'd0, 1'b0, 1'b0};
    tbl[11] = '{1056, 1'b1, 1'b0, 10'd0,    10'd1, 1'b0, 1'b1};

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    repeat (5) tick();

    chk("rst_word_pos", 32'(w0), 32'h0);
    chk("rst_fs_pos",   32'(fs0), 32'h0);
    chk("rst_ls_pos",   32'(ls0), 32'h0);
    chk("rst_word_neg", 32'(w1), 32'h6);
    chk("rst_word_small", 32'(w2), 32'h0);

    rst0_n = 1'b1;
    rst1_n = 1'b1;
    rst2_n = 1'b1;

    ti = 0;
    act_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    last_fs = -1; frames = 0; f_act = 0; f_vs = 0; vs_first = -1; vs_last = -1; act_blank = 0;

    for (int c = 0; c <= 1056; c++) begin
      tick();

      if (ti < 12 && tbl[ti].idx == c) begin
        exp0 = mk(tbl[ti].xc, tbl[ti].yc, tbl[ti].hs, 1'b0, tbl[ti].act);
        chk($sformatf("word_pos@%0d", c), 32'(w0), 32'(exp0));
        chk($sformatf("fs_pos@%0d", c),   32'(fs0), 32'(tbl[ti].fs));
        chk($sformatf("ls_pos@%0d", c),   32'(ls0), 32'(tbl[ti].ls));
        chk($sformatf("word_neg@%0d", c), 32'(w1), 32'(exp0 ^ 26'h6));
        ti++;
      end

      if (c < 1056) begin
        if (w0[0]) act_cnt++;
        if (w0[2]) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = c;
          hs_last = c;
        end
      end

      if (fs2) begin
        if (last_fs >= 0) begin
          chk("small_frame_period", 32'(c - last_fs), 32'd120);
          if (frames == 1) begin
            chk("small_active_count", 32'(f_act), 32'd32);
            chk("small_vs_count",     32'(f_vs), 32'd30);
            chk("small_vs_first",     32'(vs_first), 32'd75);
            chk("small_vs_last",      32'(vs_last), 32'd104);
          end
        end
        last_fs = c;
        frames++;
      end
      if (frames == 1) begin
        if (w2[0]) f_act++;
        if (w2[1]) begin
          f_vs++;
          if (vs_first < 0) vs_first = c;
          vs_last = c;
        end
      end
      if (w2[0] && (w2[12:3] >= 10'd4)) act_blank++;
    end

    chk("line0_active_count", 32'(act_cnt), 32'd800);
    chk("line0_hs_count",     32'(hs_cnt), 32'd128);
    chk("line0_hs_first",     32'(hs_first), 32'd840);
    chk("line0_hs_last",      32'(hs_last), 32'd967);
    chk("small_frame_pulses", 32'(frames), 32'd9);
    chk("small_active_in_vblank", 32'(act_blank), 32'd0);

    // Mid-frame reset: line 1, h=500
    for (int c = 1057; c <= 1556; c++) tick();
    chk("pre_reset_word", 32'(w0), 32'(mk(10'd500, 10'd1, 1'b0, 1'b0, 1'b1)));
    rst0_n = 1'b0;
    tick();
    chk("mid_reset_word", 32'(w0), 32'h0);
    chk("mid_reset_fs",   32'(fs0), 32'h0);
    chk("mid_reset_ls",   32'(ls0), 32'h0);
    rst0_n = 1'b1;
    tick();
    chk("restart_word", 32'(w0), 32'(mk(10'd0, 10'd0, 1'b0, 1'b0, 1'b1)));
    chk("restart_fs",   32'(fs0), 32'h1);
    chk("restart_ls",   32'(ls0), 32'h1);
    tick();
    chk("restart_next_word", 32'(w0), 32'(mk(10'd1, 10'd0, 1'b0, 1'b0, 1'b1)));
    chk("restart_next_fs",   32'(fs0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
